// File: rtl/seq_divmod_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divmod_if
// Purpose  : Operand/result handshake bundle for the sequential divider.
//            Operands travel master->slave on an in_valid/in_ready handshake;
//            results travel slave->master on an out_valid/out_ready handshake.
// Signals  : in_valid, in_ready, a[NA], b[NB]          - operand channel
//            out_valid, out_ready, q[NA], r[NB], div_zero - result channel
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divmod_if #(
  parameter int NA = 16,
  parameter int NB = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [NA-1:0] a;
  logic [NB-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [NA-1:0] q;
  logic [NB-1:0] r;
  logic          div_zero;

  // Requester side: presents operands, consumes results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div_zero
  );
endinterface : seq_divmod_if
`default_nettype wire

// File: rtl/seq_divmod.sv
`default_nettype none
// ============================================================================
// Module   : seq_divmod
// Purpose  : Multi-cycle unsigned divider, radix-2 restoring, one quotient
//            bit per clock. Divide-by-zero bypasses the iteration and returns
//            an all-ones quotient with the low dividend bits as remainder.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            dm   - seq_divmod_if.slave (operand and result handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module seq_divmod #(
  parameter int NA = 16,
  parameter int NB = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  seq_divmod_if.slave    dm
);

  localparam int CW = $clog2(NA + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_in_ready;
  logic          w_out_valid;

  logic [NA-1:0] r_qsh;      // dividend shifts out the top, quotient shifts in
  logic [NB-1:0] r_rem;      // partial remainder, always < r_b
  logic [NB-1:0] r_b;        // captured divisor
  logic [CW-1:0] r_cnt;      // quotient bits still to produce
  logic [NA-1:0] r_q_out;
  logic [NB-1:0] r_r_out;
  logic          r_div_zero;

  logic          w_accept;
  logic          w_b_zero;
  logic          w_last;
  logic [NB:0]   w_t;
  logic [NB:0]   w_diff;
  logic          w_ge;
  logic [NB-1:0] w_rem_next;
  logic [NA-1:0] w_qsh_next;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (dm.in_valid) begin
          w_state_next = w_b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (dm.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  assign w_accept = (r_state == S_IDLE) && dm.in_valid;
  assign w_b_zero = (dm.b == '0);
  assign w_last   = (r_cnt == CW'(1));

  // Because rem < b, t = 2*rem + bit <= 2*b - 1, so t - b always fits in NB
  // bits when t >= b; the extra (borrow) bit of the NB+1 subtract is then
  // exactly the "t < b" flag.
  assign w_t        = {r_rem, r_qsh[NA-1]};
  assign w_diff     = w_t - {1'b0, r_b};
  assign w_ge       = ~w_diff[NB];
  assign w_rem_next = w_ge ? w_diff[NB-1:0] : w_t[NB-1:0];
  assign w_qsh_next = {r_qsh[NA-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qsh      <= '0;
      r_rem      <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_q_out    <= '0;
      r_r_out    <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_b_zero) begin
          r_q_out    <= '1;
          r_r_out    <= dm.a[NB-1:0];
          r_div_zero <= 1'b1;
        end else begin
          r_qsh <= dm.a;
          r_rem <= '0;
          r_b   <= dm.b;
          r_cnt <= CW'(NA);
        end
      end else if (r_state == S_RUN) begin
        r_qsh <= w_qsh_next;
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - CW'(1);
        // Result registers only update on the final step so Q/R stay frozen
        // at the previous result while the next division is in progress.
        if (w_last) begin
          r_q_out    <= w_qsh_next;
          r_r_out    <= w_rem_next;
          r_div_zero <= 1'b0;
        end
      end
    end
  end

  assign dm.in_ready  = w_in_ready;
  assign dm.out_valid = w_out_valid;
  assign dm.q         = r_q_out;
  assign dm.r         = r_r_out;
  assign dm.div_zero  = r_div_zero;

endmodule : seq_divmod
`default_nettype wire

// File: doc/seq_divmod.md
Name: seq_divmod

Overview:
Multi-cycle unsigned divider: the sequential inverse of the multiply path in the combinational binop blocks. It takes an NA-bit dividend and an NB-bit divisor and returns the quotient and remainder. It uses radix-2 restoring division, one quotient bit per clock. The block sits behind the arithmetic datapath so that wide divide/modulo operations do not create a long combinational path. Operands enter through a valid/ready handshake and results leave through another valid/ready handshake.

Parameters:
NA, 16, dividend and quotient width (>= 2)
NB, 8, divisor and remainder width (>= 1, <= NA)

Ports:
CLK  in  1  clock, all state changes on rising edge
RST  in  1  reset, asynchronous, active-high
IN_VALID  in  1  operand presented
IN_READY  out  1  block can accept operands
A  in  NA  dividend, unsigned
B  in  NB  divisor, unsigned
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer accepts result
Q  out  NA  quotient
R  out  NB  remainder
DIV_ZERO  out  1  result came from B == 0

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, Q=0, R=0, DIV_ZERO=0, internal counter=0.
- States:
  - IDLE: IN_READY=1.
  - RUN: IN_READY=0, OUT_VALID=0.
  - DONE: IN_READY=0, OUT_VALID=1.
- IDLE:
  - On an edge with IN_VALID=1, capture A and B.
  - If B != 0, go to RUN with counter=NA, partial remainder=0, quotient register=A.
  - If B == 0, go straight to DONE with Q = all ones, R = A[NB-1:0], DIV_ZERO=1.
- RUN, one edge per quotient bit:
  - Form t = {rem, q[NA-1]}, NB+1 bits.
  - If t >= B: rem = t - B and shift 1 into q. Otherwise rem = t[NB-1:0] and shift 0 into q.
  - The quotient register shifts left, new bit in at bit 0. The counter decrements.
  - When the counter reaches 0 after its update, go to DONE and present Q and R with DIV_ZERO=0.
- Widths:
  - The compare/subtract is done at NB+1 bits.
  - rem < B is invariant, so the final R always fits in NB bits.
  - No truncation warnings are permitted on the datapath.
- Latency:
  - Operands accepted at edge E → OUT_VALID high after edge E+NA.
  - B == 0 → OUT_VALID high after edge E.
- DONE:
  - Q, R and DIV_ZERO hold stable while OUT_VALID=1 and OUT_READY=0 (backpressure, any duration).
  - On an edge with OUT_READY=1, go to IDLE: OUT_VALID=0, IN_READY=1. Q, R and DIV_ZERO keep their last values.
- No overlap: a new operand is never accepted in the same edge that a result is consumed. Throughput is at most one operation per NA+2 cycles.
- IN_VALID while IN_READY=0 is ignored. A and B changes during RUN or DONE have no effect.
- OUT_READY in IDLE or RUN is ignored.
- RST asserted mid-RUN or in DONE: all outputs return immediately to their reset values. The in-flight operation is dropped and no result is produced.
- Q and R are registered outputs with no combinational path from inputs to outputs. IN_READY and OUT_VALID are decoded from the state register only.

Test Plan:
- A=1000, B=7: IN_VALID pulse in IDLE → OUT_VALID exactly 16 edges after capture, Q=142, R=6, DIV_ZERO=0.
- A=65535, B=255, then A=5, B=9 back-to-back with OUT_READY=1 → Q=257, R=0; then Q=0, R=5. IN_READY stays low from capture through the consume edge.
- A=0x1234, B=0 → OUT_VALID after 1 edge, Q=0xFFFF, R=0x34, DIV_ZERO=1. The next normal operation returns DIV_ZERO=0.
- A=40000, B=3 with OUT_READY held 0 for 10 cycles after OUT_VALID → Q=13333 and R=1 stay stable and OUT_VALID stays 1. Release → IDLE one edge later.
- Assert RST 5 cycles into RUN (A=500, B=4) → OUT_VALID=0, Q=0 and IN_READY=1 asynchronously. After release, A=500, B=4 → Q=125, R=0.
- Randomised: 1000 operand pairs, including B=1, B=2^NB-1, A<B and A=0, against a Q=A/B, R=A%B model → all match. Latency is always NA edges.
